// File: rtl/switch_pkg.sv
// switch_pkg
//   Shared constants for the DIP-switch conditioning path: system clock rate,
//   debounce window, switch count, and the counter-width helper used by the
//   per-bit debouncer.
package switch_pkg;

    localparam int SYS_CLK_HZ              = 24_000_000;
    localparam int DEBOUNCE_MS             = 10;
    localparam int DEBOUNCE_CYCLES_DEFAULT = SYS_CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int SW_WIDTH                = 4;

    typedef logic [SW_WIDTH-1:0] sw_vec_t;

    // Counter width able to hold 0 .. cycles-1; never narrower than one bit
    // so the degenerate single-cycle window still has a legal vector.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage : switch_pkg

// File: rtl/debounce_bit.sv
// debounce_bit
//   One switch bit: 2-flop synchronizer, mismatch counter and registered
//   clean/changed outputs. A new level is accepted only after it has been
//   seen on the synchronized input for DEBOUNCE_CYCLES consecutive edges.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   d_raw      raw asynchronous switch pin
//   d_clean    debounced level
//   d_changed  one-cycle pulse in the cycle d_clean updates
module debounce_bit
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic d_raw,
    output logic d_clean,
    output logic d_changed
);

    localparam int                 CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // NOTE: every flop here, counter included, is cleared by reset so a
    // partially qualified level cannot survive a reset and leak into d_clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            d_clean   <= 1'b0;
            d_changed <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make sync2 take the old sync1,
            // giving two real flop stages with nothing between them.
            sync1     <= d_raw;
            sync2     <= sync1;
            d_changed <= 1'b0;

            if (sync2 == d_clean) begin
                // Any return to the accepted level restarts the window.
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                d_clean   <= sync2;
                d_changed <= 1'b1;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Conditions the raw DIP-switch vector for led_control: each bit is
//   synchronized and debounced independently, yielding a stable vector and a
//   per-bit one-cycle change pulse. All outputs are registered.
//
// Ports
//   clk        system clock (24 MHz)
//   reset      asynchronous, active-high reset
//   s_raw      raw asynchronous switch pins
//   s_clean    debounced switch vector (feeds led_control s)
//   s_changed  per-bit pulse, high in the cycle s_clean[i] updates
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_raw,
    output logic [WIDTH-1:0] s_clean,
    output logic [WIDTH-1:0] s_changed
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .d_raw    (s_raw[i]),
            .d_clean  (s_clean[i]),
            .d_changed(s_changed[i])
        );
    end

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
//   Two instances (window 4 and window 1) driven by the same stimulus and
//   compared every cycle against a history-window model: a bit flips when the
//   last D synchronized samples all disagree with the accepted level.
module tb_switch_debouncer;
    import switch_pkg::*;

    localparam int W   = SW_WIDTH;
    localparam int D_A = 4;
    localparam int D_B = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] s_raw;
    logic [W-1:0] clean_a, chg_a, clean_b, chg_b;

    always #5 clk = ~clk;

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D_A)) dut (
        .clk(clk), .reset(reset), .s_raw(s_raw),
        .s_clean(clean_a), .s_changed(chg_a)
    );

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D_B)) dut_fast (
        .clk(clk), .reset(reset), .s_raw(s_raw),
        .s_clean(clean_b), .s_changed(chg_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] pipe1, pipe2;     // raw value delayed by one / two edges
    logic [W-1:0] hist[$];          // synchronized samples seen at each edge
    logic [W-1:0] mc_a, mg_a, mc_b, mg_b;

    task automatic model_reset();
        pipe1 = '0; pipe2 = '0; hist.delete();
        mc_a = '0; mg_a = '0; mc_b = '0; mg_b = '0;
    endtask

    // True when the last d samples of bit b all differ from level cur.
    function automatic logic window_flips(int d, int b, logic cur);
        if (hist.size() < d) return 1'b0;
        for (int j = 0; j < d; j++)
            if (hist[hist.size() - 1 - j][b] == cur) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            hist.push_back(pipe2);
            if (hist.size() > 16) void'(hist.pop_front());
            pipe2 = pipe1;
            pipe1 = s_raw;
            mg_a = '0; mg_b = '0;
            for (int b = 0; b < W; b++) begin
                if (window_flips(D_A, b, mc_a[b])) begin
                    mc_a[b] = ~mc_a[b]; mg_a[b] = 1'b1;
                end
                if (window_flips(D_B, b, mc_b[b])) begin
                    mc_b[b] = ~mc_b[b]; mg_b[b] = 1'b1;
                end
            end
        end
    endtask

    // One clock: model advances at the edge, DUT compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("clean_a",   32'(clean_a), 32'(mc_a));
        check("changed_a", 32'(chg_a),   32'(mg_a));
        check("clean_b",   32'(clean_b), 32'(mc_b));
        check("changed_b", 32'(chg_b),   32'(mg_b));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int n;

    initial begin
        model_reset();
        reset = 1'b1;
        s_raw = 4'b1111;
        #1;
        check("rst_clean", 32'(clean_a), 32'h0);
        check("rst_chg",   32'(chg_a),   32'h0);
        ticks(3);

        // Release with switches held high: full window from scratch.
        reset = 1'b0;
        ticks(5);
        check("rel_pre_clean", 32'(clean_a), 32'h0);
        tick();
        check("rel_clean", 32'(clean_a), 32'hF);
        check("rel_chg",   32'(chg_a),   32'hF);
        tick();
        check("rel_chg_off", 32'(chg_a), 32'h0);

        // Back to all-low, then raise bit 0 only.
        s_raw = 4'b0000;
        ticks(8);
        s_raw = 4'b0001;
        n = 0;
        do begin tick(); n++; end while (!clean_a[0] && n < 20);
        check("lat_bit0", 32'(n), 32'd6);
        check("bit0_only", 32'(clean_a), 32'h1);
        ticks(3);

        // Short pulse on bit 2 is rejected by the 4-cycle window.
        s_raw[2] = 1'b1;
        ticks(3);
        s_raw[2] = 1'b0;
        ticks(8);
        check("glitch_bit2", 32'(clean_a[2]), 32'h0);

        // Bounce on bit 1: 1,0 then held 1; timing counts from the final rise.
        s_raw[1] = 1'b1; tick();
        s_raw[1] = 1'b0; tick();
        s_raw[1] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!clean_a[1] && n < 20);
        check("lat_bounce", 32'(n), 32'd6);
        ticks(3);

        // All four bits flip together.
        s_raw = 4'b1010;
        ticks(10);
        check("pre_swap", 32'(clean_a), 32'hA);
        s_raw = 4'b0101;
        n = 0;
        do begin tick(); n++; end while (chg_a == 4'b0000 && n < 20);
        check("lat_swap", 32'(n), 32'd6);
        check("swap_chg", 32'(chg_a), 32'hF);
        check("swap_clean", 32'(clean_a), 32'h5);
        ticks(3);

        // Asynchronous reset while bit 3 is mid-count.
        s_raw = 4'b1101;
        ticks(4);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_clean", 32'(clean_a), 32'h0);
        check("async_chg",   32'(chg_a),   32'h0);
        check("async_clean_b", 32'(clean_b), 32'h0);
        ticks(2);
        reset = 1'b0;
        n = 0;
        do begin tick(); n++; end while (clean_a != 4'b1101 && n < 20);
        check("lat_after_rst", 32'(n), 32'd6);
        ticks(2);

        // Random stimulus: mostly steady with occasional multi-bit bounces.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0)
                s_raw = s_raw ^ 4'($urandom_range(15));
            if ($urandom_range(299) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_switch_debouncer

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the raw 4-bit DIP-switch input before it reaches the on-board LED control and seven-segment logic.
- Each bit passes through a 2-flop synchronizer, then an independent per-bit debounce counter.
- Produces a clean, stable switch vector plus a one-cycle change pulse per bit.
- Sits between the FPGA switch pins and the `s` input of led_control.

Parameters:
- WIDTH, 4, number of switch bits conditioned.
- DEBOUNCE_CYCLES, 240000, consecutive clk cycles a new level must persist before acceptance (10 ms at 24 MHz); legal range >= 1.

Ports:
- clk  input  1  system clock (24 MHz HSOSC-derived).
- reset  input  1  asynchronous, active-high reset.
- s_raw  input  WIDTH  raw, asynchronous switch pins.
- s_clean  output  WIDTH  debounced switch vector; feeds led_control `s`.
- s_changed  output  WIDTH  per-bit one-cycle pulse, high in the cycle s_clean[i] updates.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
  - While reset is high: sync stages, counters, s_clean and s_changed are all 0.
  - Deassertion needs no synchronizer requirement beyond the top-level one.
- Synchronizer: sync1[i] <= s_raw[i]; sync2[i] <= sync1[i]. No logic between the flops.
- Counter per bit, width CNT_W = max(1, $clog2(DEBOUNCE_CYCLES)).
  - Each rising edge where sync2[i] == s_clean[i]: cnt[i] <= 0, s_changed[i] <= 0.
  - Each rising edge where sync2[i] != s_clean[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1, s_changed[i] <= 0.
  - Each rising edge where sync2[i] != s_clean[i] and cnt[i] == DEBOUNCE_CYCLES-1: s_clean[i] <= sync2[i], cnt[i] <= 0, s_changed[i] <= 1.
- Latency: if s_raw[i] changes and is captured at edge 1, s_clean[i] and s_changed[i] update at edge DEBOUNCE_CYCLES+2, provided the level holds the whole time.
- Glitch rejection: any return to the accepted level before acceptance clears the counter. The bit must then restart a full DEBOUNCE_CYCLES window.
- DEBOUNCE_CYCLES == 1: acceptance at the first mismatch edge (edge 3).
- The counter never wraps; the maximum value held is DEBOUNCE_CYCLES-1.
- Bits are fully independent. Simultaneous changes on several bits are accepted in the same cycle with multiple s_changed bits high.
- s_changed is high for exactly one cycle per accepted transition, both rising and falling.
- Reset mid-count: the counter is discarded and s_clean returns to 0. A switch held high re-qualifies from scratch, reaching s_clean at edge DEBOUNCE_CYCLES+2 after reset release.
- All outputs are registered. No combinational path from s_raw to any output.

Decomposition:
- Package switch_pkg holds:
  - SYS_CLK_HZ = 24_000_000
  - DEBOUNCE_MS = 10
  - DEBOUNCE_CYCLES_DEFAULT = SYS_CLK_HZ/1000*DEBOUNCE_MS
  - SW_WIDTH = 4
- Sub-module debounce_bit holds one synchronizer, counter and output flop (ports clk, reset, d_raw, d_clean, d_changed). switch_debouncer instantiates WIDTH copies in a generate loop.

Test Plan (bench overrides DEBOUNCE_CYCLES=4):
- Reset held, s_raw=4'b1111 -> s_clean=4'b0000, s_changed=0. After release with s_raw held, s_clean=4'b1111 at edge 6 post-release, s_changed=4'b1111 for exactly that one cycle.
- From s_clean=0, s_raw[0] set to 1 and held -> s_clean[0]=1 at edge 6 after the capture edge; s_changed[0] pulses one cycle. Other bits stay 0.
- s_raw[2] pulses high for 3 cycles, then low -> s_clean[2] stays 0, s_changed stays 0. Internal counter returns to 0.
- s_raw bounces 1,0,1,1,1,1,1 on bit 1 (one cycle each, then held) -> acceptance counts from the final rise only; s_clean[1]=1 exactly 6 edges after the last rise is captured.
- s_clean=4'b1010, s_raw switched to 4'b0101 in one cycle -> all four bits update at the same edge; s_changed=4'b1111 for one cycle; s_clean=4'b0101.
- Reset asserted asynchronously mid-count (cnt=2) on bit 3 -> s_clean and s_changed go to 0 immediately without a clock edge. After release, the bit needs the full 6 edges again.
